// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian word RAM behind a valid/ready request port.
// Supports byte/half/word loads and stores with wait states and error reporting.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    output logic [31:0]       ReadData,
    output logic              resp_valid,
    output logic              err
);

    localparam int unsigned       IW      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [3:0]        WS_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q, re_q, sgn_q;
    logic [1:0]        size_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0] mem_q [DEPTH] = '{default: '0};

    // From IDLE the access may commit on the accept edge itself (no wait
    // states), so the live inputs are used until the request is latched.
    logic              in_idle;
    logic [ADDR_W-1:0] a;
    logic [31:0]       wd;
    logic              we, re, sg;
    logic [1:0]        sz;

    assign in_idle = (state_q == S_IDLE);
    assign a   = in_idle ? Address   : addr_q;
    assign wd  = in_idle ? WriteData : wdata_q;
    assign we  = in_idle ? MemWrite  : we_q;
    assign re  = in_idle ? MemRead   : re_q;
    assign sz  = in_idle ? MemSize   : size_q;
    assign sg  = in_idle ? MemSigned : sgn_q;

    logic          err_c, enter_resp, commit;
    logic [IW-1:0] widx;
    logic [31:0]   word, shifted, load_c, rdata_c, wword;
    logic [3:0]    wmask;

    assign widx = a[2 +: IW];
    assign word = mem_q[widx];

    always_comb begin
        err_c = (sz == 2'b11)
              || (sz == 2'b01 && a[0])
              || (sz == 2'b10 && a[1:0] != 2'b00)
              || ((a >> 2) >= DEPTH_A)
              || (we && re);
        shifted = word >> {a[1:0], 3'b000};
        case (sz)
            2'b00:   load_c = sg ? {{24{shifted[7]}},  shifted[7:0]}  : {24'h0, shifted[7:0]};
            2'b01:   load_c = sg ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
            default: load_c = word;
        endcase
        rdata_c = (err_c || !re) ? '0 : load_c;
        case (sz)
            2'b00: begin
                wword = {4{wd[7:0]}};
                wmask = 4'b0001 << a[1:0];
            end
            2'b01: begin
                wword = {2{wd[15:0]}};
                wmask = a[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wword = wd;
                wmask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d   = '0;
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WS_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign commit     = rst_n && enter_resp && we && !err_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_idle && req_valid) begin
                addr_q  <= Address;
                wdata_q <= WriteData;
                we_q    <= MemWrite;
                re_q    <= MemRead;
                sgn_q   <= MemSigned;
                size_q  <= MemSize;
            end
            if (enter_resp) begin
                rdata_q <= rdata_c;
                err_q   <= err_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wmask[i]) mem_q[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    assign req_ready  = in_idle;
    assign resp_valid = (state_q == S_RESP);
    assign ReadData   = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl: one instance with one wait
// state and one with none for back-to-back throughput.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        req_valid, MemWrite, MemRead, MemSigned;
    logic [31:0] Address, WriteData;
    logic [1:0]  MemSize;
    logic        req_ready, resp_valid, err;
    logic [31:0] ReadData;

    logic        rv0, we0, re0, sg0;
    logic [31:0] a0, wd0;
    logic [1:0]  sz0;
    logic        rdy0, rsp0, err0;
    logic [31:0] rd0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(32), .DEPTH(256), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemSize(MemSize), .MemSigned(MemSigned), .ReadData(ReadData),
        .resp_valid(resp_valid), .err(err)
    );

    data_mem_ctrl #(.ADDR_W(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rdy0),
        .Address(a0), .WriteData(wd0), .MemWrite(we0), .MemRead(re0),
        .MemSize(sz0), .MemSigned(sg0), .ReadData(rd0),
        .resp_valid(rsp0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request on the WAIT_STATES=1 instance; called #1 after a rising edge.
    task automatic req(input string tag, input logic w, input logic r, input logic [1:0] s,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        int low;
        req_valid = 1'b1; MemWrite = w; MemRead = r; MemSize = s;
        MemSigned = sg; Address = a; WriteData = wd;
        chk({tag, "_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        Address = 32'hDEAD_BEEF; WriteData = 32'h0BAD_F00D; MemSize = 2'b11;
        lat = 1; low = 0;
        while (!resp_valid && lat < 20) begin
            if (!req_ready) low++;
            @(posedge clk); #1;
            lat++;
        end
        if (!req_ready) low++;
        chk({tag, "_resp"}, resp_valid, 1);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_low"}, low, 2);
        chk({tag, "_rd"}, ReadData, exp_rd);
        chk({tag, "_err"}, err, exp_err);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {resp_valid, req_ready}, 2'b01);
        chk({tag, "_hold"}, {err, ReadData}, {exp_err, exp_rd});
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; MemSize = 2'b10;
        MemSigned = 1'b0; Address = '0; WriteData = '0;
        rv0 = 1'b0; we0 = 1'b0; re0 = 1'b0; sz0 = 2'b10; sg0 = 1'b0; a0 = '0; wd0 = '0;
        @(posedge clk); #1;
        chk("rst_ws1", {req_ready, resp_valid, err, ReadData}, {3'b100, 32'h0});
        chk("rst_ws0", {rdy0, rsp0, err0, rd0}, {3'b100, 32'h0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        req("t1_st",  1, 0, 2'b10, 0, 32'd20, 32'h9999_9999, 32'h0,         0);
        req("t1_ld",  0, 1, 2'b10, 0, 32'd20, 32'h0,         32'h9999_9999, 0);

        req("t2_stw", 1, 0, 2'b10, 0, 32'd40, 32'hEEEE_EEEE, 32'h0,         0);
        req("t2_stb", 1, 0, 2'b00, 0, 32'd41, 32'hFFFF_FF12, 32'h0,         0);
        req("t2_ldw", 0, 1, 2'b10, 1, 32'd40, 32'h0,         32'hEEEE_12EE, 0);
        req("t2_lbs41", 0, 1, 2'b00, 1, 32'd41, 32'h0,       32'h0000_0012, 0);
        req("t2_lbs40", 0, 1, 2'b00, 1, 32'd40, 32'h0,       32'hFFFF_FFEE, 0);
        req("t2_lbu40", 0, 1, 2'b00, 0, 32'd40, 32'h0,       32'h0000_00EE, 0);
        req("t2_lhs42", 0, 1, 2'b01, 1, 32'd42, 32'h0,       32'hFFFF_EEEE, 0);
        req("t2_lhu42", 0, 1, 2'b01, 0, 32'd42, 32'h0,       32'h0000_EEEE, 0);

        req("t3_sth21", 1, 0, 2'b01, 0, 32'd21, 32'h1234_5678, 32'h0,       1);
        req("t3_stw22", 1, 0, 2'b10, 0, 32'd22, 32'h1234_5678, 32'h0,       1);
        req("t3_ld20",  0, 1, 2'b10, 0, 32'd20, 32'h0,       32'h9999_9999, 0);
        req("t3_sz11",  0, 1, 2'b11, 0, 32'd20, 32'h0,       32'h0,         1);

        req("t4_oor",   0, 1, 2'b10, 0, 32'd1024, 32'h0,     32'h0,         1);
        req("t4_both",  1, 1, 2'b10, 0, 32'd20, 32'h5A5A_5A5A, 32'h0,       1);
        req("t4_ld20",  0, 1, 2'b10, 0, 32'd20, 32'h0,       32'h9999_9999, 0);
        req("t4_nop",   0, 0, 2'b10, 0, 32'd20, 32'h0,       32'h0,         0);

        // Reset during WAIT: the pending store must not commit.
        req_valid = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; MemSize = 2'b10;
        Address = 32'd20; WriteData = 32'h5555_5555;
        @(posedge clk); #1;
        req_valid = 1'b0; MemWrite = 1'b0;
        chk("t5_inwait", {req_ready, resp_valid}, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("t5_rst", {req_ready, resp_valid, err, ReadData}, {3'b100, 32'h0});
        @(posedge clk); #1;
        chk("t5_rst_hold", {req_ready, resp_valid}, 2'b10);
        rst_n = 1'b1;
        @(posedge clk); #1;
        req("t5_ld20", 0, 1, 2'b10, 0, 32'd20, 32'h0, 32'h9999_9999, 0);

        // Back-to-back on the zero-wait instance with req_valid held high.
        begin
            logic [31:0] exp_q [4];
            int k;
            exp_q[0] = 32'h0; exp_q[1] = 32'h1111_1111;
            exp_q[2] = 32'h0; exp_q[3] = 32'h2222_2222;
            k = 0;
            rv0 = 1'b1;
            for (int cyc = 0; cyc < 8; cyc++) begin
                chk("t6_ready", rdy0, (cyc % 2 == 0) ? 1 : 0);
                chk("t6_resp",  rsp0, (cyc % 2 == 1) ? 1 : 0);
                if (rsp0 && k > 0) begin
                    chk("t6_rd",  rd0,  exp_q[k-1]);
                    chk("t6_err", err0, 0);
                end
                if (rdy0 && k < 4) begin
                    a0 = 32'd8; sz0 = 2'b10;
                    we0 = (k % 2 == 0); re0 = (k % 2 == 1);
                    wd0 = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
                    k++;
                end
                @(posedge clk); #1;
            end
            rv0 = 1'b0;
            chk("t6_count", k, 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
